// File: rtl/hazard_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hazard_if : pipeline <-> hazard unit signal bundle.  Rev 1.0
// ---------------------------------------------------------------------------
interface hazard_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       rs1_D, rs2_D;
  logic [4:0]       rs1_E, rs2_E, rd_E;
  logic [4:0]       rd_M, rd_W;
  logic             ctrl_register_file_WE_E, ctrl_register_file_WE_M, ctrl_register_file_WE_W;
  logic             ctrl_result_E;
  logic             branch_taken_E;
  logic             mem_req_M, mem_ready_M;
  logic             stall_F, stall_D, stall_E, stall_M;
  logic             flush_D, flush_E, flush_W;
  logic [1:0]       forward_A_E, forward_B_E;
  logic             mem_fault;
  logic [CNT_W-1:0] stall_cycles, flush_events;

  // master: the hazard unit itself; slave: the pipeline it controls
  modport master (
    input  rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W,
    input  ctrl_register_file_WE_E, ctrl_register_file_WE_M, ctrl_register_file_WE_W,
    input  ctrl_result_E, branch_taken_E, mem_req_M, mem_ready_M,
    output stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W,
    output forward_A_E, forward_B_E, mem_fault, stall_cycles, flush_events
  );

  modport slave (
    output rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W,
    output ctrl_register_file_WE_E, ctrl_register_file_WE_M, ctrl_register_file_WE_W,
    output ctrl_result_E, branch_taken_E, mem_req_M, mem_ready_M,
    input  stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W,
    input  forward_A_E, forward_B_E, mem_fault, stall_cycles, flush_events
  );
endinterface
`default_nettype wire

// File: rtl/hazard_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hazard_unit : stall/flush/forwarding control for the 5-stage RISC-V core.
// Rev 1.0
// ---------------------------------------------------------------------------
module hazard_unit #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  wire logic clk,
  input  wire logic rst,
  hazard_if.master  hz
);
  localparam int          WCW  = $clog2(MEM_TIMEOUT + 1) + 1;
  localparam logic [0:0]  RUN  = 1'b0;
  localparam logic [0:0]  WAIT = 1'b1;

  logic [0:0]       state;
  logic [WCW-1:0]   wait_cnt;
  logic             fault;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic             mem_freeze, lw_stall, branch_act;
  logic [31:0]      wait_next;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (hz.ctrl_register_file_WE_M && hz.rd_M != 5'd0 && hz.rd_M == rs)
      return 2'b10;
    else if (hz.ctrl_register_file_WE_W && hz.rd_W != 5'd0 && hz.rd_W == rs)
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign hz.forward_A_E = fwd_sel(hz.rs1_E);
  assign hz.forward_B_E = fwd_sel(hz.rs2_E);

  assign mem_freeze = hz.mem_req_M & ~hz.mem_ready_M;
  assign lw_stall   = hz.ctrl_result_E & hz.ctrl_register_file_WE_E & (hz.rd_E != 5'd0) &
                      ((hz.rd_E == hz.rs1_D) | (hz.rd_E == hz.rs2_D));
  assign branch_act = hz.branch_taken_E & ~mem_freeze;

  always_comb begin
    hz.stall_F = 1'b0;
    hz.stall_D = 1'b0;
    hz.stall_E = 1'b0;
    hz.stall_M = 1'b0;
    hz.flush_D = 1'b0;
    hz.flush_E = 1'b0;
    hz.flush_W = 1'b0;
    if (mem_freeze) begin
      // Everything holds; a bubble drains into writeback while memory waits
      hz.stall_F = 1'b1;
      hz.stall_D = 1'b1;
      hz.stall_E = 1'b1;
      hz.stall_M = 1'b1;
      hz.flush_W = 1'b1;
    end else if (hz.branch_taken_E) begin
      hz.flush_D = 1'b1;
      hz.flush_E = 1'b1;
    end else if (lw_stall) begin
      hz.stall_F = 1'b1;
      hz.stall_D = 1'b1;
      hz.flush_E = 1'b1;
    end
  end

  // Fault is judged on the count value this cycle's increment produces
  assign wait_next = 32'(wait_cnt) + 32'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= '0;
      fault    <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (mem_freeze) begin
            state    <= WAIT;
            wait_cnt <= '0;
            if (MEM_TIMEOUT <= 1) fault <= 1'b1;
          end
        end
        default: begin
          if (!mem_freeze) begin
            state <= RUN;
          end else begin
            if (wait_cnt != '1) wait_cnt <= wait_cnt + WCW'(1);
            if (wait_next >= 32'(MEM_TIMEOUT - 1)) fault <= 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (hz.stall_F && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      if (branch_act && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign hz.mem_fault    = fault;
  assign hz.stall_cycles = stall_cnt;
  assign hz.flush_events = flush_cnt;
endmodule
`default_nettype wire

// File: tb/tb_hazard_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_hazard_unit : directed vector table plus clocked corner-case sequences.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_hazard_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  hazard_if #(.CNT_W(4)) hz ();
  hazard_unit #(.CNT_W(4), .MEM_TIMEOUT(4)) dut (.clk(clk), .rst(rst), .hz(hz));

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
    logic       we_E, we_M, we_W, res_E, br, req, rdy;
    logic [3:0] stall;   // {F,D,E,M}
    logic [2:0] flush;   // {D,E,W}
    logic [1:0] fa, fb;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v);
    hz.rs1_D = v.rs1_D; hz.rs2_D = v.rs2_D;
    hz.rs1_E = v.rs1_E; hz.rs2_E = v.rs2_E; hz.rd_E = v.rd_E;
    hz.rd_M = v.rd_M; hz.rd_W = v.rd_W;
    hz.ctrl_register_file_WE_E = v.we_E;
    hz.ctrl_register_file_WE_M = v.we_M;
    hz.ctrl_register_file_WE_W = v.we_W;
    hz.ctrl_result_E = v.res_E; hz.branch_taken_E = v.br;
    hz.mem_req_M = v.req; hz.mem_ready_M = v.rdy;
    #1;
  endtask

  task automatic idle();
    apply('{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0,
            1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 3'h0, 2'b00, 2'b00});
  endtask

  task automatic load_use(input logic br);
    apply('{5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0,
            1'b1, 1'b0, 1'b0, 1'b1, br, 1'b0, 1'b0, 4'h0, 3'h0, 2'b00, 2'b00});
  endtask

  task automatic freeze(input logic rdy);
    apply('{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0,
            1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, rdy, 4'h0, 3'h0, 2'b00, 2'b00});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [3:0] stalls();
    return {hz.stall_F, hz.stall_D, hz.stall_E, hz.stall_M};
  endfunction

  function automatic logic [2:0] flushes();
    return {hz.flush_D, hz.flush_E, hz.flush_W};
  endfunction

  initial begin
    //          rs1D  rs2D  rs1E  rs2E  rdE   rdM   rdW   weE  weM  weW  ldE  br   req  rdy  stall flush fa     fb
    vecs[0]  = '{5'd0, 5'd0, 5'd5, 5'd3, 5'd0, 5'd5, 5'd5, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 4'h0, 3'h0, 2'b10, 2'b00};
    vecs[1]  = '{5'd0, 5'd0, 5'd5, 5'd3, 5'd0, 5'd5, 5'd5, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 4'h0, 3'h0, 2'b01, 2'b00};
    vecs[2]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 4'h0, 3'h0, 2'b00, 2'b00};
    vecs[3]  = '{5'd0, 5'd0, 5'd9, 5'd9, 5'd0, 5'd9, 5'd9, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 4'h0, 3'h0, 2'b01, 2'b01};
    vecs[4]  = '{5'd1, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 4'hC, 3'h2, 2'b00, 2'b00};
    vecs[5]  = '{5'd7, 5'd2, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 4'hC, 3'h2, 2'b00, 2'b00};
    vecs[6]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 4'h0, 3'h0, 2'b00, 2'b00};
    vecs[7]  = '{5'd7, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 4'h0, 3'h0, 2'b00, 2'b00};
    vecs[8]  = '{5'd7, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 4'h0, 3'h0, 2'b00, 2'b00};
    vecs[9]  = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0, 4'h0, 3'h6, 2'b00, 2'b00};
    vecs[10] = '{5'd0, 5'd7, 5'd4, 5'd0, 5'd7, 5'd4, 5'd0, 1'b1,1'b1,1'b0,1'b1,1'b1,1'b1,1'b0, 4'hF, 3'h1, 2'b10, 2'b00};
    vecs[11] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1, 4'h0, 3'h0, 2'b00, 2'b00};
    vecs[12] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 4'h0, 3'h0, 2'b00, 2'b00};

    // Reset state
    idle();
    rst = 1'b1;
    tick();
    tick();
    check("rst_stall_cycles", 32'(hz.stall_cycles), 32'd0);
    check("rst_flush_events", 32'(hz.flush_events), 32'd0);
    check("rst_mem_fault", 32'(hz.mem_fault), 32'd0);
    check("rst_state", 32'(dut.state), 32'd0);

    // Combinational vectors, applied while held in reset
    for (int i = 0; i < 13; i++) begin
      apply(vecs[i]);
      check($sformatf("vec%0d_stall", i), 32'(stalls()), 32'(vecs[i].stall));
      check($sformatf("vec%0d_flush", i), 32'(flushes()), 32'(vecs[i].flush));
      check($sformatf("vec%0d_fwdA", i), 32'(hz.forward_A_E), 32'(vecs[i].fa));
      check($sformatf("vec%0d_fwdB", i), 32'(hz.forward_B_E), 32'(vecs[i].fb));
    end
    idle();
    rst = 1'b0;

    // Load-use: single bubble, counted one edge later
    do_reset();
    load_use(1'b0);
    check("lu_stalls", 32'(stalls()), 32'hC);
    check("lu_cnt_before", 32'(hz.stall_cycles), 32'd0);
    tick();
    idle();
    check("lu_cnt_after", 32'(hz.stall_cycles), 32'd1);
    check("lu_released", 32'(stalls()), 32'h0);

    // Branch beats load-use
    do_reset();
    load_use(1'b1);
    check("br_lu_stalls", 32'(stalls()), 32'h0);
    check("br_lu_flush", 32'(flushes()), 32'h6);
    tick();
    idle();
    check("br_flush_events", 32'(hz.flush_events), 32'd1);
    check("br_stall_cycles", 32'(hz.stall_cycles), 32'd0);

    // Three-cycle memory wait
    do_reset();
    freeze(1'b0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("mw_stall%0d", i), 32'(stalls()), 32'hF);
      check($sformatf("mw_flush%0d", i), 32'(flushes()), 32'h1);
      tick();
    end
    freeze(1'b1);
    check("mw_ready_stall", 32'(stalls()), 32'h0);
    tick();
    idle();
    check("mw_stall_cycles", 32'(hz.stall_cycles), 32'd3);
    check("mw_state_run", 32'(dut.state), 32'd0);
    check("mw_no_fault", 32'(hz.mem_fault), 32'd0);

    // Timeout: fault after 4th frozen cycle, sticky until reset
    do_reset();
    freeze(1'b0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      check($sformatf("to_fault_k%0d", k), 32'(hz.mem_fault), (k >= 4) ? 32'd1 : 32'd0);
    end
    check("to_stall_cycles", 32'(hz.stall_cycles), 32'd6);
    idle();
    tick();
    check("to_fault_sticky", 32'(hz.mem_fault), 32'd1);
    do_reset();
    check("to_fault_cleared", 32'(hz.mem_fault), 32'd0);
    check("to_cnt_cleared", 32'(hz.stall_cycles), 32'd0);

    // Reset while waiting, with the freeze still present
    freeze(1'b0);
    tick();
    check("rw_in_wait", 32'(dut.state), 32'd1);
    rst = 1'b1;
    tick();
    check("rw_reset_run", 32'(dut.state), 32'd0);
    rst = 1'b0;
    tick();
    check("rw_reenter_wait", 32'(dut.state), 32'd1);
    idle();

    // Saturation of a 4-bit counter
    do_reset();
    load_use(1'b0);
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 14) check("sat_14", 32'(hz.stall_cycles), 32'd14);
      if (i == 15) check("sat_15", 32'(hz.stall_cycles), 32'd15);
    end
    check("sat_hold", 32'(hz.stall_cycles), 32'd15);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
